// File: rtl/hydra_sched_pkg.sv
// Shared definitions for the hydra output-port schedulers.
//   NUM_PRIO / PRIO_W : number of priority queues per port and index width
//   WEIGHT            : WRR weight per priority, WEIGHT[p] = p+1 (36 grants per round)
//   sched_state_t     : scheduler FSM states
package hydra_sched_pkg;

  localparam int NUM_PRIO = 8;
  localparam int PRIO_W   = 3;

  localparam int WEIGHT [NUM_PRIO] = '{1, 2, 3, 4, 5, 6, 7, 8};

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_t;

endpackage

// File: rtl/prio_wrr_scheduler_prio_pick.sv
// prio_pick: combinational highest-set-bit encoder.
// Ports:
//   mask  in  N  candidate bits, bit N-1 is most important
//   idx   out W  index of the highest set bit (0 when none set)
//   found out 1  at least one bit of mask is set
module prio_pick
  import hydra_sched_pkg::*;
#(
  parameter int N = NUM_PRIO,
  parameter int W = PRIO_W
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         found
);

  // Ascending scan: the last hit wins, which is the highest set bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_wrr_scheduler.sv
// prio_wrr_scheduler: per-output-port packet scheduler.
// Picks one of NUM_PRIO queues when the downstream port is ready, using strict
// priority or weighted round robin, issues a one-cycle grant and then waits
// for the packet's end-of-packet (guarded by a watchdog) before the next pick.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wrr_en        1 = weighted round robin, 0 = strict priority
//   ready         downstream wants the next packet (level or pulse)
//   q_nonempty    bit p = queue p holds a complete packet
//   pkt_eop       read engine finished the granted packet
//   grant         one-cycle pulse, read queue grant_prio
//   grant_prio    selected queue, held after the grant
//   busy          transfer in flight
//   timeout_err   one-cycle pulse when the watchdog expires
module prio_wrr_scheduler #(
  parameter int NUM_PRIO = hydra_sched_pkg::NUM_PRIO,
  parameter int PRIO_W   = hydra_sched_pkg::PRIO_W,
  parameter int CRED_W   = 4,
  parameter int TIMEOUT  = 1024,
  parameter int TO_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrr_en,
  input  logic              ready,
  input  logic [NUM_PRIO-1:0] q_nonempty,
  input  logic              pkt_eop,
  output logic              grant,
  output logic [PRIO_W-1:0] grant_prio,
  output logic              busy,
  output logic              timeout_err
);

  import hydra_sched_pkg::*;

  sched_state_t      state_reg, state_next;
  logic              ready_pend_reg, ready_pend_next;
  logic [TO_W-1:0]   wd_reg, wd_next;
  logic              grant_reg, grant_next;
  logic [PRIO_W-1:0] grant_prio_reg, grant_prio_next;
  logic              timeout_err_reg, timeout_err_next;
  logic [CRED_W-1:0] cred_reg  [NUM_PRIO];
  logic [CRED_W-1:0] cred_next [NUM_PRIO];

  logic [NUM_PRIO-1:0] eligible;
  logic [PRIO_W-1:0]   el_idx, ne_idx, sel;
  logic                el_found, ne_found;

  // A queue is WRR-eligible only with a packet waiting and credit left.
  for (genvar gi = 0; gi < NUM_PRIO; gi++) begin : g_elig
    assign eligible[gi] = q_nonempty[gi] & (cred_reg[gi] != '0);
  end

  prio_pick #(.N(NUM_PRIO), .W(PRIO_W)) u_pick_elig (
    .mask  (eligible),
    .idx   (el_idx),
    .found (el_found)
  );

  prio_pick #(.N(NUM_PRIO), .W(PRIO_W)) u_pick_ne (
    .mask  (q_nonempty),
    .idx   (ne_idx),
    .found (ne_found)
  );

  // Strict mode and the WRR reload case both take the highest nonempty queue.
  assign sel = (wrr_en && el_found) ? el_idx : ne_idx;

  always_comb begin
    state_next       = state_reg;
    ready_pend_next  = ready_pend_reg | ready;
    wd_next          = wd_reg;
    grant_next       = 1'b0;
    grant_prio_next  = grant_prio_reg;
    timeout_err_next = 1'b0;
    for (int p = 0; p < NUM_PRIO; p++) begin
      cred_next[p] = cred_reg[p];
    end

    case (state_reg)
      IDLE: begin
        if ((ready || ready_pend_reg) && ne_found) begin
          state_next      = XFER;
          grant_next      = 1'b1;
          grant_prio_next = sel;
          wd_next         = '0;
          ready_pend_next = 1'b0;
          if (wrr_en) begin
            if (el_found) begin
              cred_next[el_idx] = cred_reg[el_idx] - 1'b1;
            end else begin
              // Round exhausted: reload everyone and charge this grant.
              for (int p = 0; p < NUM_PRIO; p++) begin
                cred_next[p] = CRED_W'(WEIGHT[p]);
              end
              cred_next[ne_idx] = CRED_W'(WEIGHT[ne_idx] - 1);
            end
          end
        end
      end
      XFER: begin
        if (pkt_eop) begin
          state_next = IDLE;
        end else if (wd_reg == TO_W'(TIMEOUT - 1)) begin
          // Abort: the consumed credit stays consumed, pending ready dropped.
          state_next       = IDLE;
          timeout_err_next = 1'b1;
          ready_pend_next  = 1'b0;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      ready_pend_reg  <= 1'b0;
      wd_reg          <= '0;
      grant_reg       <= 1'b0;
      grant_prio_reg  <= '0;
      timeout_err_reg <= 1'b0;
      for (int p = 0; p < NUM_PRIO; p++) begin
        cred_reg[p] <= CRED_W'(WEIGHT[p]);
      end
    end else begin
      state_reg       <= state_next;
      ready_pend_reg  <= ready_pend_next;
      wd_reg          <= wd_next;
      grant_reg       <= grant_next;
      grant_prio_reg  <= grant_prio_next;
      timeout_err_reg <= timeout_err_next;
      for (int p = 0; p < NUM_PRIO; p++) begin
        cred_reg[p] <= cred_next[p];
      end
    end
  end

  assign grant       = grant_reg;
  assign grant_prio  = grant_prio_reg;
  assign busy        = (state_reg == XFER);
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_prio_wrr_scheduler.sv
// Directed testbench for prio_wrr_scheduler with hand-derived expectations.
module tb_prio_wrr_scheduler;

  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       wrr_en;
  logic       ready;
  logic [7:0] q_nonempty;
  logic       pkt_eop;
  logic       grant;
  logic [2:0] grant_prio;
  logic       busy;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_wrr_scheduler #(
    .NUM_PRIO (8),
    .PRIO_W   (3),
    .CRED_W   (4),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wrr_en      (wrr_en),
    .ready       (ready),
    .q_nonempty  (q_nonempty),
    .pkt_eop     (pkt_eop),
    .grant       (grant),
    .grant_prio  (grant_prio),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // new inputs applied here take effect for the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Expected prio of the k-th WRR grant with all queues full:
  // 7 x8, 6 x7, ..., 0 x1, repeating every 36 grants.
  function automatic int wrr_expect(input int k);
    int m = k % 36;
    int p = 7;
    while (m >= p + 1) begin
      m -= p + 1;
      p--;
    end
    return p;
  endfunction

  // One ready pulse, grant check, eop in the grant cycle, back to idle.
  task automatic do_grant(input string tag, input int exp_prio);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_grant"}, int'(grant), 1);
    check({tag, "_prio"}, int'(grant_prio), exp_prio);
    $display("txn %s grant=%0d prio=%0d exp=%0d", tag, grant, grant_prio, exp_prio);
    pkt_eop = 1'b1;
    tick();
    pkt_eop = 1'b0;
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    bit saw_early;
    rst = 1'b0; wrr_en = 1'b0; ready = 1'b0; q_nonempty = '0; pkt_eop = 1'b0;
    tick();
    do_reset();
    check("rst_grant", int'(grant), 0);
    check("rst_prio", int'(grant_prio), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_to", int'(timeout_err), 0);
    $display("txn reset done");

    // 1. strict priority
    wrr_en = 1'b0; q_nonempty = 8'b1000_0101; ready = 1'b1;
    tick();
    ready = 1'b0;
    check("sp_grant", int'(grant), 1);
    check("sp_prio", int'(grant_prio), 7);
    check("sp_busy", int'(busy), 1);
    tick();
    check("sp_grant_low", int'(grant), 0);
    check("sp_prio_hold", int'(grant_prio), 7);
    tick(); tick();
    check("sp_busy_held", int'(busy), 1);
    pkt_eop = 1'b1;
    tick();
    pkt_eop = 1'b0;
    check("sp_busy_drop", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sp_no_regrant", int'(grant), 0);
    end
    $display("txn strict prio grant done");

    // 2. WRR fairness over two full rounds
    do_reset();
    wrr_en = 1'b1; q_nonempty = 8'hFF;
    for (int k = 0; k < 72; k++) begin
      do_grant($sformatf("wrr%0d", k), wrr_expect(k));
    end

    // 3. ready before data
    do_reset();
    wrr_en = 1'b0; q_nonempty = 8'h00; ready = 1'b1;
    tick();
    ready = 1'b0;
    check("rbd_no_grant", int'(grant), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rbd_wait", int'(grant), 0);
    end
    q_nonempty = 8'h08;
    tick();
    check("rbd_grant", int'(grant), 1);
    check("rbd_prio", int'(grant_prio), 3);
    $display("txn ready-before-data grant=%0d prio=%0d", grant, grant_prio);
    pkt_eop = 1'b1;
    tick();
    pkt_eop = 1'b0;

    // 4. watchdog
    q_nonempty = 8'h02; ready = 1'b1;
    tick();
    ready = 1'b0;
    check("wd_grant", int'(grant), 1);
    check("wd_prio", int'(grant_prio), 1);
    saw_early = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      if (timeout_err || !busy) saw_early = 1'b1;
    end
    check("wd_no_early", int'(saw_early), 0);
    tick();
    check("wd_to_pulse", int'(timeout_err), 1);
    check("wd_busy_drop", int'(busy), 0);
    tick();
    check("wd_to_single", int'(timeout_err), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wd_no_regrant", int'(grant), 0);
    end
    $display("txn watchdog timeout observed=%0d", !saw_early);

    // 5. eop and ready in the same cycle
    q_nonempty = 8'h01; ready = 1'b1;
    tick();
    ready = 1'b0;
    check("er_grant1", int'(grant), 1);
    tick();
    pkt_eop = 1'b1; ready = 1'b1;
    tick();
    pkt_eop = 1'b0; ready = 1'b0;
    check("er_busy", int'(busy), 0);
    check("er_no_grant", int'(grant), 0);
    tick();
    check("er_grant2", int'(grant), 1);
    check("er_prio", int'(grant_prio), 0);
    $display("txn eop+ready regrant=%0d prio=%0d", grant, grant_prio);
    pkt_eop = 1'b1;
    tick();
    pkt_eop = 1'b0;

    // 6. reset mid-transfer after 3 prio-7 credits used
    do_reset();
    wrr_en = 1'b1; q_nonempty = 8'hFF;
    do_grant("pre0", 7);
    do_grant("pre1", 7);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("pre2_grant", int'(grant), 1);
    check("pre2_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_grant", int'(grant), 0);
    check("mr_prio", int'(grant_prio), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_to", int'(timeout_err), 0);
    for (int k = 0; k < 9; k++) begin
      do_grant($sformatf("post%0d", k), (k < 8) ? 7 : 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
